game_control_fsm: RTL and testbench
===================================

GAME_CONTROL_FSM -- requirements
Module: game_control_fsm

Interface
REQ-001 The module SHALL have parameter CAR_USER_Y, default 10'd400, fixed top y of the player car.
REQ-002 The module SHALL have parameter CAR_HEIGHT, default 10'd60, height of every car in pixels.
REQ-003 The module SHALL have parameter CRASH_FRAMES, default 6'd60, the crash hold time in frames.
REQ-004 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock; one clock; all logic on posedge clk.
- rst  in  1  reset; synchronous, active-high.
- sVS  in  1  vertical sync level, synchronous to clk.
- btn_start  in  1  debounced start button level.
- car_user_x  in  10  player car left x.
- car2_x, car2_y, car3_x, car3_y  in  10 each  enemy car positions.
- CAR_WIDTH  in  6  car width in pixels.
- END  out  1  freeze flag.
- internal_reset  out  1  one-cycle car re-initialise pulse.
- score  out  10  binary score, saturating at 999.
- lives  out  2  remaining lives.
- SPEED  out  3  enemy speed.

Function
REQ-005 The module SHALL register sVS once per cycle and SHALL generate frame_tick = sVS & ~sVS_q, which is high for exactly one cycle per rising edge.
REQ-006 The module SHALL generate start_tick as the rising edge of btn_start using the same one-cycle rule as frame_tick.
REQ-007 The FSM SHALL have the states IDLE, RUN, CRASH and OVER.
REQ-008 END SHALL be 0 in RUN and 1 in IDLE, CRASH and OVER.
REQ-009 The hit condition for car k SHALL be true when all of the following hold, using 11-bit unsigned arithmetic with no wrap:
- car_user_x < cark_x+CAR_WIDTH;
- cark_x < car_user_x+CAR_WIDTH;
- CAR_USER_Y < cark_y+CAR_HEIGHT;
- cark_y < CAR_USER_Y+CAR_HEIGHT.
REQ-010 The module SHALL compute hit as the OR of the car-2 and car-3 hit conditions, combinationally from the current inputs.
REQ-011 In IDLE or OVER, on start_tick the module SHALL, on the next clock edge, go to RUN, set lives=3, set score=0, set SPEED=1 and pulse internal_reset for one cycle.
REQ-012 In RUN, on a frame_tick with hit=1, the module SHALL, on the same edge, decrement lives, load the frame counter with CRASH_FRAMES and go to CRASH.
REQ-013 In RUN, on a frame_tick with hit=0, the module SHALL add 1 to score for each enemy car whose y is less than its stored previous y (a wrap), so +2 when both cars wrap, saturating at 999.
REQ-014 When a collision and a wrap occur on the same frame_tick, the collision SHALL win and score SHALL be unchanged.
REQ-015 On every frame_tick in any state, the module SHALL load the previous-y registers with the current car2_y and car3_y.
REQ-016 On every internal_reset pulse, the previous-y registers SHALL be cleared to 0.
REQ-017 In CRASH, the module SHALL decrement the frame counter on each frame_tick.
REQ-018 When the CRASH frame counter reaches 0 and lives>0, the module SHALL pulse internal_reset for one cycle and go to RUN.
REQ-019 When the CRASH frame counter reaches 0 and lives=0, the module SHALL go to OVER and SHALL NOT pulse internal_reset.
REQ-020 SPEED SHALL be registered as min(7, 1 + score/16) and SHALL update the cycle after score changes.
REQ-021 start_tick SHALL be ignored in RUN and CRASH.
REQ-022 internal_reset SHALL never be high for two consecutive cycles.
REQ-023 lives SHALL never underflow below 0.

Reset
REQ-024 rst=1 SHALL override all other behaviour on the clock edge where it is sampled.
REQ-025 Under rst=1 the module SHALL set state=IDLE, END=1, internal_reset=0, score=0, lives=3, SPEED=1, the frame counter to 0, the previous-y registers to 0, and sVS_q and btn_start_q to 0.
REQ-026 rst asserted mid-CRASH or mid-RUN SHALL discard all progress and SHALL NOT generate an internal_reset pulse.

Verification
REQ-027 Bench: rst, then btn_start 0->1 -> exactly one internal_reset cycle; state RUN; END=0; lives=3; score=0.
REQ-028 Bench: RUN; car_user_x=300, car2 at x=310 y=380, CAR_WIDTH=40; one sVS rising edge -> lives=2, END=1 the next cycle; after 60 frames, a single internal_reset pulse and END=0.
REQ-029 Bench: RUN; car2_y steps 470 -> 2 and car3_y steps 475 -> 3 on one frame with no hit -> score +2; repeat until score=16 -> SPEED=2 one cycle later.
REQ-030 Bench: RUN; car2_y wraps while car3 overlaps the player on the same frame -> score unchanged and lives decremented.
REQ-031 Bench: three collisions -> after the third CRASH hold, state OVER, lives=0, END=1, no internal_reset; btn_start then restarts with lives=3.
REQ-032 Bench: rst asserted during CRASH -> IDLE and reset values on the next edge; score stays saturated at 999 when wraps continue past 999.

Source files
------------

// File: rtl/game_control_fsm.sv
// Game flow controller: start/run/crash/game-over sequencing, collision and
// wrap scoring on each vertical-sync frame, lives and speed bookkeeping.
module game_control_fsm #(
  parameter logic [9:0] CAR_USER_Y   = 10'd400,
  parameter logic [9:0] CAR_HEIGHT   = 10'd60,
  parameter logic [5:0] CRASH_FRAMES = 6'd60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sVS,
  input  logic       btn_start,
  input  logic [9:0] car_user_x,
  input  logic [9:0] car2_x,
  input  logic [9:0] car2_y,
  input  logic [9:0] car3_x,
  input  logic [9:0] car3_y,
  input  logic [5:0] CAR_WIDTH,
  output logic       END,
  output logic       internal_reset,
  output logic [9:0] score,
  output logic [1:0] lives,
  output logic [2:0] SPEED
);

  typedef enum logic [1:0] {IDLE, RUN, CRASH, OVER} state_t;

  state_t          state_reg;
  logic            sVS_q;
  logic            btn_start_q;
  logic            frame_tick;
  logic            start_tick;
  logic [1:0][9:0] enemy_x;
  logic [1:0][9:0] enemy_y;
  logic [1:0][9:0] prev_y_reg;
  logic [1:0]      hit_vec;
  logic [1:0]      wrap_vec;
  logic            hit;
  logic [1:0]      wrap_count;
  logic [10:0]     score_sum;
  logic [9:0]      score_next;
  logic [2:0]      speed_next;
  logic [5:0]      frame_cnt_reg;
  logic            end_reg;
  logic            internal_reset_reg;
  logic [9:0]      score_reg;
  logic [1:0]      lives_reg;
  logic [2:0]      speed_reg;
  logic [10:0]     user_x_w;
  logic [10:0]     user_y_w;
  logic [10:0]     width_w;
  logic [10:0]     height_w;

  // Index 0 is car 2, index 1 is car 3.
  assign enemy_x = {car3_x, car2_x};
  assign enemy_y = {car3_y, car2_y};

  assign frame_tick = sVS & ~sVS_q;
  assign start_tick = btn_start & ~btn_start_q;

  // Widened to 11 bits so x+width and y+height never wrap near the screen edge.
  assign user_x_w = {1'b0, car_user_x};
  assign user_y_w = {1'b0, CAR_USER_Y};
  assign width_w  = {5'b0, CAR_WIDTH};
  assign height_w = {1'b0, CAR_HEIGHT};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_car
      logic [10:0] car_x_w;
      logic [10:0] car_y_w;
      assign car_x_w = {1'b0, enemy_x[gi]};
      assign car_y_w = {1'b0, enemy_y[gi]};
      assign hit_vec[gi] = (user_x_w < car_x_w + width_w) &&
                           (car_x_w < user_x_w + width_w) &&
                           (user_y_w < car_y_w + height_w) &&
                           (car_y_w < user_y_w + height_w);
      assign wrap_vec[gi] = enemy_y[gi] < prev_y_reg[gi];
    end
  endgenerate

  assign hit        = |hit_vec;
  assign wrap_count = {1'b0, wrap_vec[0]} + {1'b0, wrap_vec[1]};
  assign score_sum  = {1'b0, score_reg} + {9'b0, wrap_count};
  assign score_next = (score_sum > 11'd999) ? 10'd999 : score_sum[9:0];
  // Below 96 the quotient score/16 is at most 5, so 1+score[6:4] never exceeds 6.
  assign speed_next = (score_reg >= 10'd96) ? 3'd7 : score_reg[6:4] + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      end_reg            <= 1'b1;
      internal_reset_reg <= 1'b0;
      score_reg          <= 10'd0;
      lives_reg          <= 2'd3;
      speed_reg          <= 3'd1;
      frame_cnt_reg      <= 6'd0;
      prev_y_reg         <= '0;
      sVS_q              <= 1'b0;
      btn_start_q        <= 1'b0;
    end else begin
      sVS_q              <= sVS;
      btn_start_q        <= btn_start;
      internal_reset_reg <= 1'b0;
      speed_reg          <= speed_next;
      if (frame_tick) begin
        prev_y_reg <= enemy_y;
      end

      case (state_reg)
        IDLE, OVER: begin
          if (start_tick) begin
            state_reg          <= RUN;
            end_reg            <= 1'b0;
            lives_reg          <= 2'd3;
            score_reg          <= 10'd0;
            speed_reg          <= 3'd1;
            frame_cnt_reg      <= 6'd0;
            internal_reset_reg <= 1'b1;
            prev_y_reg         <= '0;
          end
        end
        RUN: begin
          if (frame_tick) begin
            if (hit) begin
              state_reg     <= CRASH;
              end_reg       <= 1'b1;
              lives_reg     <= (lives_reg != 2'd0) ? lives_reg - 2'd1 : 2'd0;
              frame_cnt_reg <= CRASH_FRAMES;
            end else begin
              score_reg <= score_next;
            end
          end
        end
        CRASH: begin
          // Zero is tested before counting so the hold can never underflow.
          if (frame_cnt_reg == 6'd0) begin
            if (lives_reg != 2'd0) begin
              state_reg          <= RUN;
              end_reg            <= 1'b0;
              internal_reset_reg <= 1'b1;
              prev_y_reg         <= '0;
            end else begin
              state_reg <= OVER;
              end_reg   <= 1'b1;
            end
          end else if (frame_tick) begin
            frame_cnt_reg <= frame_cnt_reg - 6'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          end_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign END            = end_reg;
  assign internal_reset = internal_reset_reg;
  assign score          = score_reg;
  assign lives          = lives_reg;
  assign SPEED          = speed_reg;

endmodule

// File: tb/tb_game_control_fsm.sv
// Bench for game_control_fsm: hit-boundary vector table, directed game
// sequences and randomized play checked against a behavioural model.
module tb_game_control_fsm;

  localparam int USER_Y  = 400;
  localparam int HEIGHT  = 60;
  localparam int HOLD    = 60;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_CRASH = 2;
  localparam int S_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sVS = 1'b0;
  logic       btn_start = 1'b0;
  logic [9:0] car_user_x = 10'd300;
  logic [9:0] car2_x = 10'd0;
  logic [9:0] car2_y = 10'd0;
  logic [9:0] car3_x = 10'd0;
  logic [9:0] car3_y = 10'd0;
  logic [5:0] CAR_WIDTH = 6'd40;
  logic       END;
  logic       internal_reset;
  logic [9:0] score;
  logic [1:0] lives;
  logic [2:0] SPEED;

  int n_checks = 0;
  int n_errors = 0;
  int ir_seen  = 0;

  int m_state, m_lives, m_score, m_speed, m_end, m_ir, m_hold;
  int m_prev2, m_prev3, m_svs, m_btn;

  typedef struct {
    int ux;
    int c2x;
    int c2y;
    int c3x;
    int c3y;
    int w;
    int exp_lives;
  } hit_vec_t;

  hit_vec_t vecs[12];

  game_control_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .sVS           (sVS),
    .btn_start     (btn_start),
    .car_user_x    (car_user_x),
    .car2_x        (car2_x),
    .car2_y        (car2_y),
    .car3_x        (car3_x),
    .car3_y        (car3_y),
    .CAR_WIDTH     (CAR_WIDTH),
    .END           (END),
    .internal_reset(internal_reset),
    .score         (score),
    .lives         (lives),
    .SPEED         (SPEED)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Half-open intervals [a, a+alen) and [b, b+blen) share at least one pixel.
  function automatic bit overlap(input int a, input int alen, input int b, input int blen);
    int lo, hi;
    lo = (a > b) ? a : b;
    hi = (a + alen < b + blen) ? a + alen : b + blen;
    return lo < hi;
  endfunction

  function automatic bit collides(input int x, input int y);
    return overlap(int'(car_user_x), int'(CAR_WIDTH), x, int'(CAR_WIDTH)) &&
           overlap(USER_Y, HEIGHT, y, HEIGHT);
  endfunction

  task automatic model_step();
    bit ft, st, h;
    int wraps, q;
    ft = (sVS == 1'b1) && (m_svs == 0);
    st = (btn_start == 1'b1) && (m_btn == 0);
    h  = collides(int'(car2_x), int'(car2_y)) || collides(int'(car3_x), int'(car3_y));
    wraps = ((int'(car2_y) < m_prev2) ? 1 : 0) + ((int'(car3_y) < m_prev3) ? 1 : 0);
    if (rst) begin
      m_state = S_IDLE; m_lives = 3; m_score = 0; m_speed = 1; m_ir = 0;
      m_hold = 0; m_prev2 = 0; m_prev3 = 0; m_svs = 0; m_btn = 0; m_end = 1;
      return;
    end
    m_svs = int'(sVS);
    m_btn = int'(btn_start);
    m_ir  = 0;
    q = 1 + m_score / 16;
    m_speed = (q > 7) ? 7 : q;
    if (ft) begin
      m_prev2 = int'(car2_y);
      m_prev3 = int'(car3_y);
    end
    if (m_state == S_IDLE || m_state == S_OVER) begin
      if (st) begin
        m_state = S_RUN; m_lives = 3; m_score = 0; m_speed = 1; m_ir = 1;
        m_prev2 = 0; m_prev3 = 0;
      end
    end else if (m_state == S_RUN) begin
      if (ft && h) begin
        m_state = S_CRASH;
        if (m_lives > 0) m_lives--;
        m_hold = HOLD;
      end else if (ft) begin
        m_score = (m_score + wraps > 999) ? 999 : m_score + wraps;
      end
    end else begin
      if (m_hold == 0) begin
        if (m_lives > 0) begin
          m_state = S_RUN; m_ir = 1; m_prev2 = 0; m_prev3 = 0;
        end else begin
          m_state = S_OVER;
        end
      end else if (ft) begin
        m_hold--;
      end
    end
    m_end = (m_state == S_RUN) ? 0 : 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("end_flag", int'(END), m_end);
    check("int_reset", int'(internal_reset), m_ir);
    check("score", int'(score), m_score);
    check("lives", int'(lives), m_lives);
    check("speed", int'(SPEED), m_speed);
    if (internal_reset) ir_seen++;
  endtask

  task automatic frame();
    sVS = 1'b1;
    tick();
    sVS = 1'b0;
    tick();
  endtask

  task automatic press();
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_cars(input int x2, input int y2, input int x3, input int y3);
    car2_x = 10'(x2);
    car2_y = 10'(y2);
    car3_x = 10'(x3);
    car3_y = 10'(y3);
  endtask

  initial begin
    // ux, car2 x/y, car3 x/y, width, lives after one frame in RUN
    vecs[0]  = '{300, 310, 380,   0,   0, 40, 2};
    vecs[1]  = '{300, 340, 380,   0,   0, 40, 3};
    vecs[2]  = '{300, 339, 380,   0,   0, 40, 2};
    vecs[3]  = '{300, 260, 400,   0,   0, 40, 3};
    vecs[4]  = '{300, 261, 400,   0,   0, 40, 2};
    vecs[5]  = '{300, 300, 340,   0,   0, 40, 3};
    vecs[6]  = '{300, 300, 341,   0,   0, 40, 2};
    vecs[7]  = '{300, 300, 460,   0,   0, 40, 3};
    vecs[8]  = '{300, 300, 459,   0,   0, 40, 2};
    vecs[9]  = '{300,   0,   0, 300, 400, 40, 2};
    vecs[10] = '{1000, 1020, 400,  0,   0, 40, 2};
    vecs[11] = '{300, 300, 400,   0,   0,  0, 3};

    // Reset then start: one internal_reset cycle, RUN with fresh counters.
    do_reset();
    check("rst_end", int'(END), 1);
    check("rst_lives", int'(lives), 3);
    ir_seen = 0;
    btn_start = 1'b1;
    tick();
    check("start_ir", int'(internal_reset), 1);
    check("start_end", int'(END), 0);
    check("start_score", int'(score), 0);
    btn_start = 1'b0;
    tick();
    tick();
    check("start_ir_count", ir_seen, 1);

    // Collision and crash hold.
    car_user_x = 10'd300;
    CAR_WIDTH  = 6'd40;
    set_cars(310, 380, 0, 0);
    sVS = 1'b1;
    tick();
    check("crash_lives", int'(lives), 2);
    check("crash_end", int'(END), 1);
    sVS = 1'b0;
    tick();
    set_cars(0, 0, 0, 0);
    ir_seen = 0;
    repeat (HOLD - 1) frame();
    check("hold_not_early_end", int'(END), 1);
    check("hold_not_early_ir", ir_seen, 0);
    frame();
    check("hold_done_ir", ir_seen, 1);
    check("hold_done_end", int'(END), 0);
    tick();
    check("hold_ir_once", ir_seen, 1);

    // Double wraps up to score 16, SPEED follows one cycle later.
    for (int i = 0; i < 7; i++) begin
      set_cars(0, 470, 0, 475);
      frame();
      set_cars(0, 2, 0, 3);
      frame();
    end
    check("wrap_score14", int'(score), 14);
    set_cars(0, 470, 0, 475);
    frame();
    set_cars(0, 2, 0, 3);
    sVS = 1'b1;
    tick();
    check("wrap_score16", int'(score), 16);
    check("speed_lag", int'(SPEED), 1);
    sVS = 1'b0;
    tick();
    check("speed_two", int'(SPEED), 2);

    // Wrap and collision on the same frame: collision wins.
    set_cars(0, 470, 0, 100);
    frame();
    set_cars(0, 2, 300, 400);
    sVS = 1'b1;
    tick();
    check("coll_wins_score", int'(score), 16);
    check("coll_wins_lives", int'(lives), 1);
    sVS = 1'b0;
    tick();

    // Reset in the middle of a crash hold.
    set_cars(0, 0, 0, 0);
    repeat (3) frame();
    ir_seen = 0;
    rst = 1'b1;
    tick();
    check("midcrash_end", int'(END), 1);
    check("midcrash_lives", int'(lives), 3);
    check("midcrash_score", int'(score), 0);
    rst = 1'b0;
    repeat (3) tick();
    check("midcrash_no_ir", ir_seen, 0);
    check("midcrash_idle", int'(END), 1);

    // Three collisions lead to OVER, then a restart.
    press();
    for (int k = 0; k < 3; k++) begin
      int exp_ir;
      exp_ir = (k < 2) ? 1 : 0;
      set_cars(310, 380, 0, 0);
      frame();
      set_cars(0, 0, 0, 0);
      ir_seen = 0;
      repeat (HOLD + 1) frame();
      tick();
      check("after_hold_ir", ir_seen, exp_ir);
      check("after_hold_end", int'(END), 1 - exp_ir);
      check("after_hold_lives", int'(lives), 2 - k);
    end
    press();
    check("restart_lives", int'(lives), 3);
    check("restart_end", int'(END), 0);

    // Score saturates at 999.
    repeat (505) begin
      set_cars(0, 470, 0, 475);
      frame();
      set_cars(0, 2, 0, 3);
      frame();
    end
    check("sat_score", int'(score), 999);
    check("sat_speed", int'(SPEED), 7);

    // Hit-boundary table.
    foreach (vecs[i]) begin
      do_reset();
      car_user_x = 10'(vecs[i].ux);
      CAR_WIDTH  = 6'(vecs[i].w);
      set_cars(vecs[i].c2x, vecs[i].c2y, vecs[i].c3x, vecs[i].c3y);
      press();
      sVS = 1'b1;
      tick();
      check($sformatf("hit_vec%0d", i), int'(lives), vecs[i].exp_lives);
      sVS = 1'b0;
      tick();
    end

    // Randomized play against the model.
    do_reset();
    car_user_x = 10'd500;
    press();
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      sVS       = ($urandom_range(0, 3) == 0);
      btn_start = ($urandom_range(0, 19) == 0);
      CAR_WIDTH = 6'($urandom_range(0, 63));
      set_cars(int'($urandom_range(440, 560)), int'($urandom_range(300, 520)),
               int'($urandom_range(440, 560)), int'($urandom_range(300, 520)));
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
